// File: rtl/counter_share_ctrl.sv
// Time-shares one WIDTH-bit up-counter between two requesters using round-robin arbitration.
// The granted requester's terminal count is latched; the counter runs 0..tc and then pulses done.
module counter_share_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] tc0,
  input  logic [WIDTH-1:0] tc1,
  input  logic             hold,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] tc_q, tc_d;
  logic             last_q, last_d;
  // Index of the requester that currently owns the counter.
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] q_inc;

  assign q_inc = q_q + WIDTH'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      q_q     <= '0;
      tc_q    <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = tc_q;
    last_d  = last_q;
    sel_d   = sel_q;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On a tie, serve whichever requester was not served last.
          sel_d   = (req0 && req1) ? ~last_q : req1;
          tc_d    = sel_d ? tc1 : tc0;
          state_d = StLoad;
        end
      end
      StLoad: begin
        q_d     = '0;
        state_d = (tc_q == '0) ? StDone : StRun;
      end
      StRun: begin
        if (!hold) begin
          q_d = q_inc;
          if (q_inc == tc_q) state_d = StDone;
        end
      end
      StDone: begin
        last_d  = sel_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy  = (state_q != StIdle);
  assign gnt0  = busy && !sel_q;
  assign gnt1  = busy && sel_q;
  assign done0 = (state_q == StDone) && !sel_q;
  assign done1 = (state_q == StDone) && sel_q;
  assign q     = q_q;

endmodule

// File: tb/tb_counter_share_ctrl.sv
// Directed self-checking bench for counter_share_ctrl: single run, tie arbitration, zero and
// maximum count, hold, and reset mid-run.
module tb_counter_share_ctrl;

  logic       clk;
  logic       reset;
  logic       req0, req1, hold;
  logic [3:0] tc0, tc1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] q;

  int total;
  int bad;
  int n;

  counter_share_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .req0  (req0),
    .req1  (req1),
    .tc0   (tc0),
    .tc1   (tc1),
    .hold  (hold),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until a done pulse is visible, bounded; n = edges taken.
  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!(done0 || done1) && cnt < 40);
    check("done_seen", 32'(done0 || done1), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    req0  = 1'b0;
    req1  = 1'b0;
    hold  = 1'b0;
    tc0   = 4'd0;
    tc1   = 4'd0;
    #2;
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt", {gnt1, gnt0}, 0);
    check("rst_done", {done1, done0}, 0);
    step();
    reset = 1'b1;

    // Single run, tc0 = 5
    req0 = 1'b1;
    tc0  = 4'd5;
    step();  // E
    check("s_gnt0_E", gnt0, 1);
    check("s_busy_E", busy, 1);
    check("s_q_E", q, 0);
    tc0 = 4'd2;  // must not affect the latched count
    step();  // E+1
    check("s_q_E1", q, 0);
    for (int k = 1; k <= 5; k++) begin
      step();
      check("s_q_run", q, k);
      check("s_done0_run", done0, (k == 5) ? 1 : 0);
    end
    req0 = 1'b0;
    step();  // E+7
    check("s_gnt0_idle", gnt0, 0);
    check("s_busy_idle", busy, 0);
    check("s_done0_idle", done0, 0);
    check("s_q_keep", q, 5);

    // Tie arbitration from reset (last = 1)
    do_reset();
    req0 = 1'b1;
    req1 = 1'b1;
    tc0  = 4'd3;
    tc1  = 4'd2;
    wait_done(n);
    check("t1_done0", done0, 1);
    check("t1_done1", done1, 0);
    check("t1_q", q, 3);
    req0 = 1'b0;
    wait_done(n);
    check("t2_done1", done1, 1);
    check("t2_q", q, 2);
    req1 = 1'b0;
    step();  // IDLE
    check("t2_idle_busy", busy, 0);
    req0 = 1'b1;
    req1 = 1'b1;
    step();
    check("t3_gnt0", gnt0, 1);
    check("t3_gnt1", gnt1, 0);
    wait_done(n);
    check("t3_done0", done0, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();

    // Zero count on requester 1
    req1 = 1'b1;
    tc1  = 4'd0;
    step();  // E
    check("z_gnt1", gnt1, 1);
    step();  // E+1
    check("z_done1", done1, 1);
    check("z_q", q, 0);
    req1 = 1'b0;
    step();
    check("z_idle", busy, 0);

    // Maximum count
    req0 = 1'b1;
    tc0  = 4'd15;
    step();  // E
    wait_done(n);
    check("m_lat", n, 16);
    check("m_q", q, 15);
    check("m_done0", done0, 1);
    req0 = 1'b0;
    step();
    check("m_q_nowrap", q, 15);

    // Hold for 3 cycles at q = 2
    req0 = 1'b1;
    tc0  = 4'd6;
    step();  // E
    step();  // q = 0
    step();  // q = 1
    step();  // q = 2
    check("h_q2", q, 2);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("h_q_frozen", q, 2);
    end
    hold = 1'b0;
    wait_done(n);
    // 3 + 3 hold edges + n edges after E; nominal tc+1 = 7
    check("h_lat", 6 + n, 10);
    check("h_q6", q, 6);
    req0 = 1'b0;
    step();

    // Reset mid-run
    req0 = 1'b1;
    tc0  = 4'd9;
    step();  // E
    for (int k = 0; k < 5; k++) step();
    check("r_q4", q, 4);
    #2;
    reset = 1'b0;
    #1;
    check("r_q0", q, 0);
    check("r_gnt", {gnt1, gnt0}, 0);
    check("r_busy", busy, 0);
    req1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("r_nodone", {done1, done0}, 0);
    end
    reset = 1'b1;
    step();
    check("r_gnt0", gnt0, 1);
    check("r_gnt1", gnt1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/counter_share_ctrl.md
# counter_share_ctrl

Controller that time-shares one WIDTH-bit up-counter between two requesters. A round-robin arbiter grants the counter to one requester at a time. The controller latches that requester's terminal count, clears and runs the counter to the terminal count, then pulses a per-requester done. It sits between the counter datapath and the blocks that need timed count runs, and owns the counter register.

## Interface
- WIDTH, 4, counter and terminal-count width
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- req0, req1  input  1  level request; a high level sampled in IDLE is a new request
- tc0, tc1  input  WIDTH  terminal count per requester; sampled only on the granting edge
- hold  input  1  freezes the counter in RUN while high
- gnt0, gnt1  output  1  one-hot grant; high in LOAD, RUN and DONE for the granted requester
- done0, done1  output  1  one-cycle pulse in DONE for the granted requester
- q  output  WIDTH  counter value
- busy  output  1  high in any state other than IDLE

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from state and registers only, with no combinational path from inputs.
- Internal registers: tc_reg (WIDTH bits) and last (1 bit, the index of the last requester served).
- IDLE:
  - Only req0 high: grant requester 0. Only req1 high: grant requester 1.
  - Both high: grant the index not equal to last.
  - On a grant: tc_reg <= tcN, gntN <= 1, next state LOAD.
  - No request: stay in IDLE; q holds its value.
- LOAD: q <= 0. Next state is DONE if tc_reg == 0, otherwise RUN.
- RUN:
  - hold = 1: q and state unchanged.
  - hold = 0: q <= q + 1. If q + 1 == tc_reg, next state DONE.
  - q never wraps, because the run ends at tc_reg ≤ 2^WIDTH − 1.
- DONE:
  - doneN = 1, gntN stays 1, q holds tc_reg.
  - hold is ignored.
  - last <= N, next state IDLE.
- In IDLE: gnt and done are 0; q keeps the final count until the next LOAD.
- Requests are only sampled in IDLE:
  - A req drop during LOAD, RUN or DONE is ignored; a run cannot be aborted except by reset.
  - A req still high in the IDLE cycle after DONE is a new request. Requesters drop req on seeing done.
- Changes to tcN after the granting edge have no effect.

## Timing
- Reset (reset = 0), applied immediately and asynchronously:
  - state = IDLE, q = 0, gnt0 = gnt1 = 0, done0 = done1 = 0, busy = 0, tc_reg = 0.
  - last = 1, so requester 0 wins the first tie.
- Reset mid-run: the run is lost, no done pulse is issued, and the requester must re-request.
- Let edge E be the edge at which IDLE samples the request:
  - After E: LOAD, gnt and busy high, q still holds the old value.
  - After E+1: q = 0; state RUN, or DONE if tc = 0.
  - After E+1+k (k = 1..tc): q = k.
  - After E+1+tc: DONE, done pulse high.
  - After E+2+tc: IDLE, gnt, done and busy low.
- Latency from the sampling edge to done high is tc + 1 edges, plus one edge per cycle that RUN spends with hold = 1.
- Back-to-back service: a new grant can occur at E+3+tc, which is the first IDLE sampling edge.

## Test plan
- Single run: release reset, hold req0 = 1, tc0 = 5. Required: gnt0 and busy high after E; q = 0 after E+1; q steps 1..5 on E+2..E+6; done0 high only in the cycle after E+6; gnt0 and busy low after E+7.
- Tie arbitration: req0 = req1 = 1 with tc0 = 3, tc1 = 2, each dropping its req on its own done. Required: requester 0 is served first (done0 with q = 3), then requester 1 (done1 with q = 2). A second simultaneous tie is won by requester 0 again, because last = 1.
- Zero count: req1 with tc1 = 0. Required: LOAD then DONE directly; done1 after E+1 with q = 0; no RUN cycle.
- Maximum count: tc0 = 15. Required: q reaches 15 with no wrap to 0; done0 pulses with q = 15.
- Hold: tc0 = 6, hold = 1 for 3 cycles while q = 2. Required: q stays at 2 for 3 cycles; done0 arrives 3 edges later than without hold.
- Reset mid-run: assert reset while q = 4 during a tc0 = 9 run. Required: q, gnt, done and busy go to 0 immediately; no done pulse follows. After release with both requests high, requester 0 is granted.
